// File: rtl/btn_conditioner_pkg.sv
// Shared constants and types for the pushbutton conditioner.
// SIM_DEBOUNCE is a short debounce count that keeps benches fast.
package btn_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 20;
  localparam int SIM_DEBOUNCE            = 4;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } db_state_e;

endpackage

// File: rtl/btn_conditioner_debounce.sv
// One button: 2-FF synchronizer, stable-count debouncer FSM, press one-shot.
// The FSM state is the debounced level and is exported on 'level'.
module btn_conditioner_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  db_state_e        state;
  db_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_next;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= RELEASED;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
    end
  end

  // Counting to TERM means this edge is the DEBOUNCE_CYCLES-th disagreeing sample.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    pulse_next = 1'b0;
    if (sync2 != (state == PRESSED)) begin
      if (cnt == TERM) begin
        state_next = (state == PRESSED) ? RELEASED : PRESSED;
        pulse_next = (state == RELEASED);
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  assign level = (state == PRESSED);

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTN raw pushbuttons into debounced levels and press strobes,
// with optional lowest-index-wins masking of coincident strobes.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int PRIORITY        = 1
) (
  input  logic               mclk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic               drop_flag
);

  logic [NUM_BTN-1:0] raw_pulse;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_conditioner_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .mclk (mclk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .pulse(raw_pulse[i])
    );
  end

  if (PRIORITY != 0) begin : g_prio
    logic drop_q;

    // x & -x isolates the lowest set bit, matching the b1 > b2 > b3 loader priority.
    assign press_pulse = raw_pulse & (~raw_pulse + NUM_BTN'(1));

    always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
        drop_q <= 1'b0;
      end else if (|(raw_pulse & ~press_pulse)) begin
        drop_q <= 1'b1;
      end
    end

    assign drop_flag = drop_q;
  end else begin : g_noprio
    assign press_pulse = raw_pulse;
    assign drop_flag   = 1'b0;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: one priority-masked and one independent
// instance share btn_raw/rst_n and are checked against a queued expectation.
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;

  localparam int NB = 3;
  localparam int D  = SIM_DEBOUNCE;
  localparam int W  = 2 * NB + 1;

  logic          mclk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] level1, pulse1, level0, pulse0;
  logic          drop1, drop0;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp0_q[$];
  int n_assert;
  int n_fail;

  btn_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .CNT_W(4), .PRIORITY(1)
  ) dut_p1 (
    .mclk(mclk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(level1), .press_pulse(pulse1), .drop_flag(drop1)
  );

  btn_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .CNT_W(4), .PRIORITY(0)
  ) dut_p0 (
    .mclk(mclk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(level0), .press_pulse(pulse0), .drop_flag(drop0)
  );

  // clock / reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Advance one rising edge and land 1 ns after it, away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  // Scoreboard: expectation is queued when the step is defined, popped when sampled.
  task automatic expect_out(input logic [NB-1:0] lvl, input logic [NB-1:0] p1,
                            input logic d1, input logic [NB-1:0] p0, input logic d0);
    exp1_q.push_back({lvl, p1, d1});
    exp0_q.push_back({lvl, p0, d0});
  endtask

  task automatic check(input string tag);
    logic [W-1:0] e1, e0, o1, o0;
    e1 = exp1_q.pop_front();
    e0 = exp0_q.pop_front();
    o1 = {level1, pulse1, drop1};
    o0 = {level0, pulse0, drop0};
    n_assert++;
    assert (o1 === e1) else begin
      n_fail++;
      $error("FAIL %s prio1: level/pulse/drop got %b/%b/%b expected %b/%b/%b", tag,
             o1[W-1 -: NB], o1[NB:1], o1[0], e1[W-1 -: NB], e1[NB:1], e1[0]);
    end
    n_assert++;
    assert (o0 === e0) else begin
      n_fail++;
      $error("FAIL %s prio0: level/pulse/drop got %b/%b/%b expected %b/%b/%b", tag,
             o0[W-1 -: NB], o0[NB:1], o0[0], e0[W-1 -: NB], e0[NB:1], e0[0]);
    end
  endtask

  task automatic step(input string tag, input logic [NB-1:0] lvl, input logic [NB-1:0] p1,
                      input logic d1, input logic [NB-1:0] p0, input logic d0);
    expect_out(lvl, p1, d1, p0, d0);
    check(tag);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    btn_raw  = 3'b111;

    // Reset held with all buttons pressed: everything stays 0.
    tick(3);
    step("reset_hold", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
    rst_n = 1'b1;
    tick(D + 1);
    step("rst_rel_pre", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
    tick();
    step("rst_rel_press", 3'b111, 3'b001, 1'b0, 3'b111, 1'b0);
    tick();
    step("rst_rel_drop", 3'b111, 3'b000, 1'b1, 3'b000, 1'b0);

    // Release all: level falls after D+2 edges, no strobe on release.
    btn_raw = 3'b000;
    tick(D + 1);
    step("rel_all_pre", 3'b111, 3'b000, 1'b1, 3'b000, 1'b0);
    tick();
    step("rel_all", 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);

    // Clean press of button 1, held for 20 cycles.
    btn_raw = 3'b010;
    tick(D + 1);
    step("b1_pre", 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);
    tick();
    step("b1_press", 3'b010, 3'b010, 1'b1, 3'b010, 1'b0);
    for (int i = 0; i < 20 - (D + 2); i++) begin
      tick();
      step("b1_hold", 3'b010, 3'b000, 1'b1, 3'b000, 1'b0);
    end
    btn_raw = 3'b000;
    tick(D + 1);
    step("b1_rel_pre", 3'b010, 3'b000, 1'b1, 3'b000, 1'b0);
    tick();
    step("b1_rel", 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);

    // Bouncing press on button 0: 1,0,1,0 then held high.
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 3'b001 : 3'b000;
      tick();
      step("b0_bounce", 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);
    end
    btn_raw = 3'b001;
    for (int i = 0; i < D + 1; i++) begin
      tick();
      step("b0_settle", 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);
    end
    tick();
    step("b0_press", 3'b001, 3'b001, 1'b1, 3'b001, 1'b0);
    tick();
    step("b0_once", 3'b001, 3'b000, 1'b1, 3'b000, 1'b0);
    btn_raw = 3'b000;
    tick(D + 2);
    step("b0_rel", 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);

    // Short glitch on button 2 shorter than the debounce count.
    btn_raw = 3'b100;
    tick(D - 1);
    btn_raw = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      step("b2_glitch", 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);
    end

    // Coincident press of buttons 1 and 2.
    btn_raw = 3'b110;
    tick(D + 2);
    step("coinc_press", 3'b110, 3'b010, 1'b1, 3'b110, 1'b0);
    tick();
    step("coinc_after", 3'b110, 3'b000, 1'b1, 3'b000, 1'b0);

    // Async reset mid-count of button 0 while button 1 stays held.
    btn_raw = 3'b011;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    step("async_rst", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
    rst_n = 1'b1;
    tick(D + 1);
    step("post_rst_pre", 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
    tick();
    step("post_rst_press", 3'b011, 3'b001, 1'b0, 3'b011, 1'b0);
    tick();
    step("post_rst_drop", 3'b011, 3'b000, 1'b1, 3'b000, 1'b0);

    n_assert++;
    assert (exp1_q.size() == 0 && exp0_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: left %0d/%0d expected 0/0", exp1_q.size(), exp0_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
